// File: rtl/imem_port_arbiter.sv
// Two-port arbiter sharing one single-ported instruction memory
// between the fetch unit and the loader/debug port.
module imem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_gnt,
    output logic        fetch_rvalid,
    output logic [31:0] fetch_rdata,
    input  logic        load_req,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata,
    output logic        load_gnt,
    output logic        load_rvalid,
    output logic [31:0] load_rdata,
    output logic        addr_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [9:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_FETCH,
        OWN_LOAD_RD
    } owner_t;

    owner_t     owner_q, owner_d;
    logic [3:0] starve_q, starve_d;
    logic       err_q, err_d;
    logic       force_fetch;
    logic       unused_bits;

    // Upper address bits are dropped: the memory aliases every 4 KiB.
    assign unused_bits = ^{fetch_addr[31:12], load_addr[31:12]};

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            starve_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        force_fetch = fetch_req && (starve_q == 4'(STARVE_MAX));
        load_gnt    = !rst && load_req && !force_fetch;
        fetch_gnt   = !rst && fetch_req && !load_gnt;

        mem_en    = fetch_gnt | load_gnt;
        mem_we    = load_gnt & load_we;
        mem_wdata = load_wdata;
        mem_addr  = load_gnt ? load_addr[11:2] : fetch_addr[11:2];

        owner_d = OWN_NONE;
        unique case (1'b1)
            fetch_gnt:             owner_d = OWN_FETCH;
            load_gnt && !load_we:  owner_d = OWN_LOAD_RD;
            default:               owner_d = OWN_NONE;
        endcase

        // Count loader wins only while fetch is actually waiting.
        starve_d = starve_q;
        if (fetch_gnt || !fetch_req) begin
            starve_d = 4'd0;
        end else if (load_gnt) begin
            starve_d = starve_q + 4'd1;
        end

        err_d = (fetch_gnt && (fetch_addr[1:0] != 2'b00))
              || (load_gnt && (load_addr[1:0] != 2'b00));

        // Reset in the response cycle kills any pending read return.
        fetch_rvalid = !rst && (owner_q == OWN_FETCH);
        load_rvalid  = !rst && (owner_q == OWN_LOAD_RD);
        fetch_rdata  = fetch_rvalid ? mem_rdata : 32'd0;
        load_rdata   = load_rvalid ? mem_rdata : 32'd0;
        addr_err     = !rst && err_q;
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Scoreboard bench for imem_port_arbiter: directed scenarios followed
// by randomized hold-until-granted traffic against a reference model.
module tb_imem_port_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_gnt, fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        load_req = 1'b0, load_we = 1'b0;
    logic [31:0] load_addr = '0, load_wdata = '0;
    logic        load_gnt, load_rvalid;
    logic [31:0] load_rdata;
    logic        addr_err, mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_port_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
        .fetch_rdata(fetch_rdata),
        .load_req(load_req), .load_we(load_we),
        .load_addr(load_addr), .load_wdata(load_wdata),
        .load_gnt(load_gnt), .load_rvalid(load_rvalid),
        .load_rdata(load_rdata), .addr_err(addr_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory device behind the arbiter: one-cycle read latency.
    logic [31:0] dev_mem [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dev_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= dev_mem[mem_addr];
        end
    end

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } rsp_t;

    rsp_t        fq[$];
    rsp_t        lq[$];
    int          eq[$];
    logic [31:0] mdl_mem [1024];
    int          streak = 0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Response monitor: each expectation is tagged with the cycle it is due.
    always @(negedge clk) begin : monitor
        rsp_t        r;
        logic        hf, hl, he;
        logic [31:0] df, dl;
        hf = 0; hl = 0; he = 0; df = '0; dl = '0;
        while (fq.size() > 0 && fq[0].cyc < cyc) begin
            void'(fq.pop_front());
            chk("fetch_rsp_lost", 1, 0);
        end
        while (lq.size() > 0 && lq[0].cyc < cyc) begin
            void'(lq.pop_front());
            chk("load_rsp_lost", 1, 0);
        end
        if (fq.size() > 0 && fq[0].cyc == cyc) begin
            r = fq.pop_front();
            hf = !rst; df = r.data;
        end
        if (lq.size() > 0 && lq[0].cyc == cyc) begin
            r = lq.pop_front();
            hl = !rst; dl = r.data;
        end
        while (eq.size() > 0 && eq[0] <= cyc) begin
            if (eq[0] == cyc) he = !rst;
            void'(eq.pop_front());
        end
        chk("fetch_rvalid", fetch_rvalid, hf);
        chk("fetch_rdata", fetch_rdata, hf ? df : 32'd0);
        chk("load_rvalid", load_rvalid, hl);
        chk("load_rdata", load_rdata, hl ? dl : 32'd0);
        chk("addr_err", addr_err, he);
    end

    // One clock of stimulus; the reference model predicts the grant
    // from the arbitration rules and queues the expected responses.
    task automatic step(input logic r, input logic fr,
                        input logic [31:0] fa, input logic lr,
                        input logic lwe, input logic [31:0] la,
                        input logic [31:0] lwd,
                        output logic ef, output logic el,
                        output logic afg);
        logic [9:0] wa;
        rst = r; fetch_req = fr; fetch_addr = fa;
        load_req = lr; load_we = lwe; load_addr = la; load_wdata = lwd;
        ef = 0; el = 0;
        if (!r) begin
            if (fr && (!lr || streak == STARVE)) ef = 1;
            else if (lr) el = 1;
        end
        streak = (!r && fr && el) ? streak + 1 : 0;
        wa = el ? la[11:2] : fa[11:2];
        if (ef) fq.push_back('{cyc + 1, mdl_mem[wa]});
        if (el && !lwe) lq.push_back('{cyc + 1, mdl_mem[wa]});
        if (el && lwe) mdl_mem[wa] = lwd;
        if ((ef && fa[1:0] != 0) || (el && la[1:0] != 0))
            eq.push_back(cyc + 1);
        @(negedge clk);
        afg = fetch_gnt;
        chk("fetch_gnt", fetch_gnt, ef);
        chk("load_gnt", load_gnt, el);
        chk("mem_en", mem_en, ef | el);
        chk("mem_we", mem_we, el & lwe);
        if (ef | el) chk("mem_addr", mem_addr, wa);
        if (el & lwe) chk("mem_wdata", mem_wdata, lwd);
        @(posedge clk);
        #1;
    endtask

    logic        ef, el, afg;
    logic        fr, lr, lwe;
    logic [31:0] fa, la, lwd;
    string       pat;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dev_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0103;
            mdl_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0103;
        end
        @(posedge clk);
        #1;
        // Reset holds every output low even with both requests up.
        step(1, 1, 32'h4, 1, 1, 32'h8, 32'h55, ef, el, afg);
        step(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, ef, el, afg);

        // Fetch-only stream at 0x8, three back-to-back grants.
        repeat (3) step(0, 1, 32'h8, 0, 0, 0, 0, ef, el, afg);

        // Contention: starvation guard forces every fifth grant to fetch.
        pat = "";
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h40, 1, 0, 32'h80, 0, ef, el, afg);
            pat = {pat, afg ? "F" : "L"};
        end
        tests++;
        if (pat != "LLLLFLLLLF") begin
            fails++;
            $display("FAIL grant_pattern: got %s expected LLLLFLLLLF", pat);
        end

        // Loader write then fetch of the same word returns the new data.
        step(0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, ef, el, afg);
        step(0, 1, 32'h10, 0, 0, 0, 0, ef, el, afg);
        // Misaligned loader read, then a 4 KiB wrap-around fetch.
        step(0, 0, 0, 1, 0, 32'h6, 0, ef, el, afg);
        step(0, 1, 32'h1004, 0, 0, 0, 0, ef, el, afg);

        // Reset in the response cycle swallows the read return.
        step(0, 1, 32'h20, 0, 0, 0, 0, ef, el, afg);
        step(1, 1, 32'h20, 0, 0, 0, 0, ef, el, afg);
        step(1, 0, 0, 0, 0, 0, 0, ef, el, afg);
        // First cycle out of reset arbitrates normally.
        step(0, 1, 32'h24, 1, 0, 32'h33, 0, ef, el, afg);
        step(0, 0, 0, 0, 0, 0, 0, ef, el, afg);

        // Random traffic; requesters hold their request until granted.
        fr = 0; lr = 0; fa = '0; la = '0; lwe = 0; lwd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!fr && ($urandom_range(3) != 0)) begin
                fr = 1;
                fa = $urandom();
                if ($urandom_range(3) != 0) fa[1:0] = 2'b00;
            end
            if (!lr && ($urandom_range(2) == 0)) begin
                lr = 1;
                lwe = $urandom_range(1);
                la = $urandom();
                la[31:8] = {$urandom_range(255), 16'h0};
                if ($urandom_range(3) != 0) la[1:0] = 2'b00;
                lwd = $urandom();
            end
            step(($urandom_range(60) == 0), fr, fa, lr, lwe, la, lwd,
                 ef, el, afg);
            if (ef) fr = 0;
            if (el) lr = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, ef, el, afg);
        step(0, 0, 0, 0, 0, 0, 0, ef, el, afg);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
